aes_req_arbiter: RTL and testbench
==================================

Name: aes_req_arbiter

Overview:
- Shares one AES cipher engine, aes_cipher_wrapper_lowaesfreq, between NREQ requesters.
- Typical requesters: instruction-fetch decrypt and data-load decrypt ports of the secure OR1200 memory path.
- Accepts requests round-robin, latches each request's key and text, and issues a single-cycle load pulse to the engine.
- Waits for done, then returns the 128-bit result to the owning requester; a watchdog flags an engine that never completes.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT, 64, clk cycles allowed between aes_ld and aes_done before an error response.
- TW, 7, timer width; must satisfy 2^TW > TIMEOUT.
- GAP, 3, minimum idle clk cycles after RESP before the next aes_ld. Must be ≥ the engine's clk_ratio+1.

Ports:
- clk  in  1  system clock; same clock as the engine's clk.
- rst  in  1  reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot accept strobe, 1 cycle.
- req_key  in  128*NREQ  key of requester i at [128*i+127:128*i].
- req_text  in  128*NREQ  plaintext/counter block of requester i.
- rsp_valid  out  NREQ  one-hot response strobe, 1 cycle.
- rsp_err  out  1  qualifies rsp_valid; 1 means timeout.
- rsp_data  out  128  result; valid while any rsp_valid bit is set.
- aes_ld  out  1  load pulse to the engine.
- aes_key  out  128  registered key to the engine.
- aes_text  out  128  registered text to the engine.
- aes_done  in  1  engine done pulse.
- aes_result  in  128  engine text_buf; sampled only when aes_done=1.

Behaviour:
- Reset: rst is synchronous, active-high.
- While rst=1, at every rising clk edge:
  - state=IDLE, gap counter=0, timer=0, last_grant=NREQ-1.
  - All outputs 0: req_ready, rsp_valid, rsp_err, rsp_data, aes_ld, aes_key, aes_text.
- States and transitions:
  - IDLE: enter only when gap counter=0.
    - If any req_valid, grant the first set bit searching upward from last_grant+1, with wrap.
    - Register g, aes_key, aes_text; assert req_ready[g]=1 for this cycle; set last_grant=g; go to ISSUE.
    - req_ready is combinational from state, gap counter and req_valid.
  - ISSUE: aes_ld=1 for exactly 1 cycle; timer=0; go to WAIT.
  - WAIT: timer increments each cycle.
    - aes_done=1: register rsp_data=aes_result and rsp_err=0; go to RESP.
    - Else timer==TIMEOUT-1: register rsp_data=0 and rsp_err=1; go to RESP.
  - RESP: rsp_valid[g]=1 for 1 cycle; load gap counter=GAP; go to IDLE.
    - The gap counter decrements to 0 while in IDLE.
- Latency: request accepted at cycle T → aes_ld at T+1. Engine done at T+1+L → rsp_valid at T+2+L.
- Handshake rules:
  - A requester holds req_valid, req_key and req_text until it sees req_ready.
  - Inputs are sampled only in the accept cycle.
  - A requester may drop req_valid without being granted.
  - The response carries no back-pressure; the requester must accept rsp_valid.
- Boundary conditions:
  - aes_done and timer==TIMEOUT-1 in the same cycle: done wins, rsp_err=0.
  - aes_done outside WAIT (stale, after a timeout): ignored; no response, no state change.
  - Only one request is outstanding at a time.
  - While not in IDLE, or while the gap counter is nonzero, req_ready is all 0.
  - Fairness: with all requesters continuously valid, grants rotate strictly 0,1,…,NREQ-1,0.
  - A sole active requester may be granted back-to-back, spaced by GAP.
  - Reset during WAIT or RESP: the transaction is dropped and no rsp_valid is issued. A subsequent aes_done is ignored.
  - aes_key and aes_text stay stable from ISSUE until the next accept. The engine may sample them on its slower clock.

Decomposition:
- Shared package/defines: state encodings AR_IDLE=2'd0, AR_ISSUE=2'd1, AR_WAIT=2'd2, AR_RESP=2'd3, plus the width constant AES_BLK=128.
- One sub-module: aes_rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: req[NREQ], last[$clog2(NREQ)].
  - Outputs: gnt_onehot, gnt_idx, any.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single request, requester 0: text=0x00112233445566778899aabbccddeeff, key=0x000102030405060708090a0b0c0d0e0f, engine model L=20.
  → req_ready[0] at T; aes_ld pulse at T+1; rsp_valid[0] at T+22; rsp_data=0x69c4e0d86a7b0430d8cdb78070b4c55a; rsp_err=0.
- Both requesters valid at the same time after reset (last_grant=1).
  → Requester 0 is granted first; requester 1 is granted exactly GAP+1 cycles after rsp_valid[0]; responses arrive in order 0, 1.
- Engine model never asserts done.
  → rsp_valid[g] with rsp_err=1 and rsp_data=0 exactly TIMEOUT+1 cycles after aes_ld. A later injected aes_done causes no output activity.
- aes_done asserted on the cycle where timer==TIMEOUT-1.
  → rsp_err=0 and rsp_data=aes_result.
- rst pulsed for 1 cycle mid-WAIT.
  → All outputs 0 on the next cycle; the pending aes_done is ignored; a fresh request afterwards completes normally.
- Requesters 0 and 1 held valid for 8 transactions with NREQ=2.
  → Grant sequence is 0,1,0,1,0,1,0,1; no back-to-back aes_ld pulses closer than GAP+2 cycles.

Source files
------------

// File: rtl/aes_req_arbiter_pkg.sv
// Shared definitions for the AES request arbiter and its round-robin picker.
// State encodings are fixed so that other arbiters can reuse them.
package aes_req_arbiter_pkg;

    localparam int AES_BLK = 128;

    typedef enum logic [1:0] {
        AR_IDLE  = 2'd0,
        AR_ISSUE = 2'd1,
        AR_WAIT  = 2'd2,
        AR_RESP  = 2'd3
    } ar_state_t;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: grants the first set request found
// searching upward from i_last+1, wrapping around.
module aes_rr_pick #(
    parameter int NREQ = 2,
    parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [LW-1:0]   i_last,
    output logic [NREQ-1:0] o_gnt_onehot,
    output logic [LW-1:0]   o_gnt_idx,
    output logic            o_any
);

    logic [LW-1:0] w_cand;

    always_comb begin
        o_gnt_onehot = '0;
        o_gnt_idx    = '0;
        o_any        = 1'b0;
        w_cand       = '0;
        // k=1 is the highest-priority slot, k=NREQ wraps back to i_last itself
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = LW'((int'(i_last) + k) % NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (!o_any && i_req[i] && (w_cand == LW'(i))) begin
                    o_any           = 1'b1;
                    o_gnt_idx       = LW'(i);
                    o_gnt_onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES engine between NREQ requesters: round-robin accept, one load
// pulse, wait for done (with watchdog), single-cycle response to the owner.
//   IDLE  | wait for gap to expire, accept a request
//   ISSUE | aes_ld pulse, clear watchdog
//   WAIT  | wait for aes_done or watchdog expiry
//   RESP  | rsp_valid to owner, arm the post-response gap
module aes_req_arbiter
    import aes_req_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7,
    parameter int GAP     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [AES_BLK*NREQ-1:0]   req_key,
    input  logic [AES_BLK*NREQ-1:0]   req_text,
    output logic [NREQ-1:0]           rsp_valid,
    output logic                      rsp_err,
    output logic [AES_BLK-1:0]        rsp_data,
    output logic                      aes_ld,
    output logic [AES_BLK-1:0]        aes_key,
    output logic [AES_BLK-1:0]        aes_text,
    input  logic                      aes_done,
    input  logic [AES_BLK-1:0]        aes_result
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    ar_state_t          r_state;
    ar_state_t          w_state_nxt;
    logic [LW-1:0]      r_last_grant;
    logic [TW-1:0]      r_timer;
    logic [GW-1:0]      r_gap;
    logic [AES_BLK-1:0] r_aes_key;
    logic [AES_BLK-1:0] r_aes_text;
    logic [AES_BLK-1:0] r_rsp_data;
    logic               r_rsp_err;

    logic [NREQ-1:0]    w_pick_oh;
    logic [LW-1:0]      w_pick_idx;
    logic               w_pick_any;
    logic               w_accept;
    logic               w_tmo;
    logic [AES_BLK-1:0] w_key_sel;
    logic [AES_BLK-1:0] w_text_sel;

    aes_rr_pick #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_pick (
        .i_req        (req_valid),
        .i_last       (r_last_grant),
        .o_gnt_onehot (w_pick_oh),
        .o_gnt_idx    (w_pick_idx),
        .o_any        (w_pick_any)
    );

    always_comb begin
        w_key_sel  = '0;
        w_text_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_idx == LW'(i)) begin
                w_key_sel  = req_key[i*AES_BLK +: AES_BLK];
                w_text_sel = req_text[i*AES_BLK +: AES_BLK];
            end
        end
    end

    always_comb begin
        w_accept  = (r_state == AR_IDLE) && (r_gap == '0) && w_pick_any;
        req_ready = w_accept ? w_pick_oh : '0;
        aes_ld    = (r_state == AR_ISSUE);
        w_tmo     = (r_timer == TW'(TIMEOUT - 1));
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = (r_state == AR_RESP) && (r_last_grant == LW'(i));
        end
    end

    assign aes_key  = r_aes_key;
    assign aes_text = r_aes_text;
    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= AR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            AR_IDLE:  if (w_accept) w_state_nxt = AR_ISSUE;
            AR_ISSUE: w_state_nxt = AR_WAIT;
            AR_WAIT:  if (aes_done || w_tmo) w_state_nxt = AR_RESP;
            AR_RESP:  w_state_nxt = AR_IDLE;
            default:  w_state_nxt = AR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= LW'(NREQ - 1);
            r_timer      <= '0;
            r_gap        <= '0;
            r_aes_key    <= '0;
            r_aes_text   <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                AR_IDLE: begin
                    if (r_gap != '0) r_gap <= r_gap - 1'b1;
                    if (w_accept) begin
                        r_last_grant <= w_pick_idx;
                        r_aes_key    <= w_key_sel;
                        r_aes_text   <= w_text_sel;
                    end
                end
                AR_ISSUE: r_timer <= '0;
                AR_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // done takes priority over a watchdog expiring in the same cycle
                    if (aes_done) begin
                        r_rsp_data <= aes_result;
                        r_rsp_err  <= 1'b0;
                    end else if (w_tmo) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                AR_RESP: begin
                    r_gap      <= GW'(GAP);
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter: engine model, per-requester drivers,
// and a scoreboard of expected grants and responses.
module tb_aes_req_arbiter;
    import aes_req_arbiter_pkg::*;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 64;
    localparam int TW      = 7;
    localparam int GAP     = 3;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [128*NREQ-1:0]     req_key;
    logic [128*NREQ-1:0]     req_text;
    logic [NREQ-1:0]         rsp_valid;
    logic                    rsp_err;
    logic [127:0]            rsp_data;
    logic                    aes_ld;
    logic [127:0]            aes_key;
    logic [127:0]            aes_text;
    logic                    aes_done;
    logic [127:0]            aes_result;

    aes_req_arbiter #(
        .NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW), .GAP(GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_text(req_text),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .aes_ld(aes_ld), .aes_key(aes_key), .aes_text(aes_text),
        .aes_done(aes_done), .aes_result(aes_result)
    );

    always #5 clk = ~clk;

    typedef struct { logic [127:0] k; logic [127:0] t; } kt_t;
    typedef struct { int who; int gap; } gnt_t;
    typedef struct { int who; bit err; logic [127:0] data; int lat; } exp_t;

    kt_t  rq[NREQ][$];
    gnt_t grant_q[$];
    exp_t exp_q[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_ld = -1000, last_ready = -1000, last_rsp = -1000;
    int ld_cnt = 0, rsp_cnt = 0;

    int           eng_lat = 20;
    bit           eng_mute = 1'b0;
    bit           inj_pend = 1'b0;
    logic [127:0] inj_val = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] eng_fn(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return k ^ {t[63:0], t[127:64]} ^ 128'hA5A5_0F0F_3C3C_9696_5A5A_F0F0_C3C3_6969;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Engine model: done pulse eng_lat cycles after the load pulse
    initial begin
        int           cnt;
        logic [127:0] k, t;
        cnt = 0;
        aes_done = 1'b0;
        aes_result = '0;
        forever begin
            @(negedge clk);
            aes_done = 1'b0;
            if (inj_pend) begin
                aes_done = 1'b1;
                aes_result = inj_val;
                inj_pend = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    aes_done = 1'b1;
                    aes_result = eng_fn(k, t);
                end
            end
            if (aes_ld && !eng_mute) begin
                k = aes_key;
                t = aes_text;
                cnt = eng_lat;
            end
        end
    end

    // Requester drivers and output monitor
    initial begin
        bit   busy[NREQ];
        bit   acc[NREQ];
        kt_t  kt;
        gnt_t g;
        exp_t e;
        req_valid = '0;
        req_key = '0;
        req_text = '0;
        for (int i = 0; i < NREQ; i++) begin busy[i] = 1'b0; acc[i] = 1'b0; end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin acc[i] = 1'b0; busy[i] = 1'b0; req_valid[i] = 1'b0; end
                if (!busy[i] && rq[i].size() > 0) begin
                    kt = rq[i].pop_front();
                    req_key[i*128 +: 128] = kt.k;
                    req_text[i*128 +: 128] = kt.t;
                    req_valid[i] = 1'b1;
                    busy[i] = 1'b1;
                end
            end
            #1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) acc[i] = 1'b1;
            if (req_ready != '0) begin
                last_ready = cyc;
                if (grant_q.size() > 0) begin
                    g = grant_q.pop_front();
                    check("grant", req_ready, NREQ'(1) << g.who);
                    if (g.gap >= 0) check("grant_gap", cyc - last_rsp, g.gap);
                end else check("unexp_ready", req_ready, 0);
            end
            if (aes_ld) begin
                ld_cnt++;
                check("ld_after_ready", cyc - last_ready, 1);
                check("ld_spacing", (cyc - last_ld) >= GAP + 2, 1);
                last_ld = cyc;
            end
            if (rsp_valid != '0) begin
                rsp_cnt++;
                last_rsp = cyc;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rsp_who", rsp_valid, NREQ'(1) << e.who);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_data", rsp_data, e.data);
                    if (e.lat >= 0) check("rsp_lat", cyc - last_ld, e.lat);
                end else check("unexp_rsp", rsp_valid, 0);
            end
        end
    end

    task automatic push_req(input int who, input logic [127:0] k, input logic [127:0] t,
                            input int gexp, input int lat, input bit err, input logic [127:0] data);
        kt_t  kt;
        gnt_t g;
        exp_t e;
        kt.k = k; kt.t = t;
        g.who = who; g.gap = gexp;
        e.who = who; e.err = err; e.data = data; e.lat = lat;
        rq[who].push_back(kt);
        grant_q.push_back(g);
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int max, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_done"}, exp_q.size(), 0);
        exp_q.delete();
        grant_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {req_ready, rsp_valid, rsp_err, aes_ld}, 0);
        check({tag, "_key"}, aes_key, 0);
        check({tag, "_text"}, aes_text, 0);
        check({tag, "_data"}, rsp_data, 0);
    endtask

    task automatic pulse_rst(input string tag);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_zero(tag);
    endtask

    initial begin
        logic [127:0] k, t;
        int base, n;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // single FIPS-197 request on requester 0
        eng_lat = 20;
        push_req(0, FIPS_KEY, FIPS_PT, -1, 21, 1'b0, FIPS_CT);
        wait_done(100, "fips");

        // simultaneous requests after reset: 0 first, 1 after the gap
        pulse_rst("rst2");
        eng_lat = 10;
        k = rnd128(); t = rnd128();
        push_req(0, k, t, -1, 11, 1'b0, eng_fn(k, t));
        k = rnd128(); t = rnd128();
        push_req(1, k, t, GAP + 1, 11, 1'b0, eng_fn(k, t));
        wait_done(200, "pair");

        // engine never completes, then a stale done arrives
        eng_mute = 1'b1;
        push_req(1, rnd128(), rnd128(), -1, TIMEOUT + 1, 1'b1, '0);
        wait_done(200, "timeout");
        eng_mute = 1'b0;
        base = rsp_cnt;
        inj_val = rnd128();
        inj_pend = 1'b1;
        repeat (12) @(posedge clk);
        check("stale_done", rsp_cnt, base);

        // done coincides with the last watchdog cycle
        eng_lat = TIMEOUT;
        k = rnd128(); t = rnd128();
        push_req(0, k, t, -1, TIMEOUT + 1, 1'b0, eng_fn(k, t));
        wait_done(200, "edge");

        // reset mid-WAIT drops the transaction
        eng_lat = 20;
        base = ld_cnt;
        push_req(1, rnd128(), rnd128(), -1, -1, 1'b0, '0);
        n = 0;
        while (ld_cnt == base && n < 50) begin @(posedge clk); n++; end
        check("rst_ld_seen", ld_cnt, base + 1);
        repeat (5) @(posedge clk);
        base = rsp_cnt;
        pulse_rst("rst_wait");
        exp_q.delete();
        grant_q.delete();
        repeat (30) @(posedge clk);
        check("rst_drop", rsp_cnt, base);
        eng_lat = 5;
        k = rnd128(); t = rnd128();
        push_req(0, k, t, -1, 6, 1'b0, eng_fn(k, t));
        wait_done(100, "after_rst");

        // fairness: both requesters continuously valid for 8 transactions
        pulse_rst("rst_fair");
        eng_lat = 4;
        for (int j = 0; j < 4; j++) begin
            k = rnd128(); t = rnd128();
            push_req(0, k, t, (j == 0) ? -1 : GAP + 1, 5, 1'b0, eng_fn(k, t));
            k = rnd128(); t = rnd128();
            push_req(1, k, t, GAP + 1, 5, 1'b0, eng_fn(k, t));
        end
        wait_done(400, "fair");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
